// File: rtl/icache_fetch_arbiter.sv
// Round-robin arbiter sharing one I-cache fetch port between two instruction fetch units.
// Keeps one fetch in flight; a jump cancels that fetch so its response is never forwarded.
module icache_fetch_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int INST_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              way0_request_i,
  input  logic [ADDR_W-1:0] way0_instAddr_i,
  output logic              way0_dataOk_o,
  output logic [INST_W-1:0] way0_inst_o,
  input  logic              way1_request_i,
  input  logic [ADDR_W-1:0] way1_instAddr_i,
  output logic              way1_dataOk_o,
  output logic [INST_W-1:0] way1_inst_o,
  input  logic              jumpFlag_i,
  output logic              icache_request_o,
  output logic [ADDR_W-1:0] icache_addr_o,
  input  logic              icache_dataOk_i,
  input  logic [INST_W-1:0] icache_inst_i,
  output logic              grant_o,
  output logic              timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;

  state_t            state_reg, state_next;
  logic              grant_reg, grant_next;
  logic              ptr_reg, ptr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              timeout_reg, timeout_next;
  logic [INST_W-1:0] inst0_reg, inst1_reg;
  logic              fwd0, fwd1;
  logic              sel;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      grant_reg   <= 1'b0;
      ptr_reg     <= 1'b0;
      addr_reg    <= '0;
      cnt_reg     <= '0;
      timeout_reg <= 1'b0;
      inst0_reg   <= '0;
      inst1_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      grant_reg   <= grant_next;
      ptr_reg     <= ptr_next;
      addr_reg    <= addr_next;
      cnt_reg     <= cnt_next;
      timeout_reg <= timeout_next;
      if (fwd0) inst0_reg <= icache_inst_i;
      if (fwd1) inst1_reg <= icache_inst_i;
    end
  end

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    ptr_next   = ptr_reg;
    addr_next  = addr_reg;
    cnt_next   = cnt_reg;
    fwd0       = 1'b0;
    fwd1       = 1'b0;
    // Priority way wins if it requests, otherwise the other way.
    if (ptr_reg) sel = way1_request_i ? 1'b1 : 1'b0;
    else         sel = way0_request_i ? 1'b0 : 1'b1;

    case (state_reg)
      IDLE: begin
        if (!jumpFlag_i && (way0_request_i || way1_request_i)) begin
          state_next = BUSY;
          grant_next = sel;
          addr_next  = sel ? way1_instAddr_i : way0_instAddr_i;
          cnt_next   = '0;
        end
      end
      BUSY: begin
        if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
        if (icache_dataOk_i) begin
          state_next = IDLE;
          ptr_next   = ~grant_reg;
          // A way that dropped its request mid-fetch no longer wants the data.
          if (!jumpFlag_i) begin
            fwd0 = !grant_reg && way0_request_i;
            fwd1 = grant_reg && way1_request_i;
          end
        end else if (jumpFlag_i) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
        if (icache_dataOk_i) begin
          state_next = IDLE;
          ptr_next   = ~grant_reg;
        end
      end
      default: state_next = IDLE;
    endcase

    timeout_next = timeout_reg | (cnt_next == CNT_MAX);
  end

  assign icache_request_o = (state_reg != IDLE);
  assign icache_addr_o    = addr_reg;
  assign grant_o          = grant_reg;
  assign timeout_o        = timeout_reg;
  assign way0_dataOk_o    = fwd0;
  assign way1_dataOk_o    = fwd1;
  assign way0_inst_o      = fwd0 ? icache_inst_i : inst0_reg;
  assign way1_inst_o      = fwd1 ? icache_inst_i : inst1_reg;

endmodule

// File: tb/tb_icache_fetch_arbiter.sv
// Directed bench for icache_fetch_arbiter: a per-cycle vector table plus hand-written
// sequences for drain, timeout and mid-fetch reset.
module tb_icache_fetch_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        way0_request_i = 1'b0;
  logic [31:0] way0_instAddr_i = '0;
  logic        way0_dataOk_o;
  logic [31:0] way0_inst_o;
  logic        way1_request_i = 1'b0;
  logic [31:0] way1_instAddr_i = '0;
  logic        way1_dataOk_o;
  logic [31:0] way1_inst_o;
  logic        jumpFlag_i = 1'b0;
  logic        icache_request_o;
  logic [31:0] icache_addr_o;
  logic        icache_dataOk_i = 1'b0;
  logic [31:0] icache_inst_i = '0;
  logic        grant_o;
  logic        timeout_o;

  int checks = 0;
  int errors = 0;

  icache_fetch_arbiter #(.ADDR_W(32), .INST_W(32), .TIMEOUT_CYC(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .way0_request_i   (way0_request_i),
    .way0_instAddr_i  (way0_instAddr_i),
    .way0_dataOk_o    (way0_dataOk_o),
    .way0_inst_o      (way0_inst_o),
    .way1_request_i   (way1_request_i),
    .way1_instAddr_i  (way1_instAddr_i),
    .way1_dataOk_o    (way1_dataOk_o),
    .way1_inst_o      (way1_inst_o),
    .jumpFlag_i       (jumpFlag_i),
    .icache_request_o (icache_request_o),
    .icache_addr_o    (icache_addr_o),
    .icache_dataOk_i  (icache_dataOk_i),
    .icache_inst_i    (icache_inst_i),
    .grant_o          (grant_o),
    .timeout_o        (timeout_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        r0;
    logic [31:0] a0;
    logic        r1;
    logic [31:0] a1;
    logic        jmp;
    logic        dok;
    logic [31:0] inst;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_gnt;
    logic        e_ok0;
    logic        e_ok1;
    logic [31:0] e_inst0;
    logic [31:0] e_inst1;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(logic rst, logic r0, logic [31:0] a0, logic r1, logic [31:0] a1,
                              logic jmp, logic dok, logic [31:0] inst, logic e_req,
                              logic [31:0] e_addr, logic e_gnt, logic e_ok0, logic e_ok1,
                              logic [31:0] e_inst0, logic [31:0] e_inst1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.a1 = a1;
    v.jmp = jmp; v.dok = dok; v.inst = inst;
    v.e_req = e_req; v.e_addr = e_addr; v.e_gnt = e_gnt;
    v.e_ok0 = e_ok0; v.e_ok1 = e_ok1; v.e_inst0 = e_inst0; v.e_inst1 = e_inst1;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: inputs applied just after the rising edge, outputs sampled mid-cycle.
  task automatic drive(logic r0, logic [31:0] a0, logic r1, logic [31:0] a1,
                       logic jmp, logic dok, logic [31:0] inst);
    @(posedge clk);
    #1;
    way0_request_i = r0; way0_instAddr_i = a0;
    way1_request_i = r1; way1_instAddr_i = a1;
    jumpFlag_i = jmp; icache_dataOk_i = dok; icache_inst_i = inst;
    #3;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    way0_request_i = 1'b0; way1_request_i = 1'b0;
    jumpFlag_i = 1'b0; icache_dataOk_i = 1'b0; icache_inst_i = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    // rst r0 a0 r1 a1 jmp dok inst | req addr gnt ok0 ok1 inst0 inst1
    vecs[0]  = mk(0,1,32'h8000_0000,0,0,0,0,0,                 0,32'h0,0,0,0,32'h0,32'h0);
    vecs[1]  = mk(0,1,32'h8000_0000,0,0,0,0,0,                 1,32'h8000_0000,0,0,0,32'h0,32'h0);
    vecs[2]  = mk(0,1,32'h8000_0000,0,0,0,0,0,                 1,32'h8000_0000,0,0,0,32'h0,32'h0);
    vecs[3]  = mk(0,1,32'h8000_0000,0,0,0,1,32'h0010_0093,     1,32'h8000_0000,0,1,0,32'h0010_0093,32'h0);
    vecs[4]  = mk(0,0,0,0,0,0,0,0,                             0,32'h8000_0000,0,0,0,32'h0010_0093,32'h0);
    vecs[5]  = mk(1,0,0,0,0,0,0,0,                             0,32'h0,0,0,0,32'h0,32'h0);
    vecs[6]  = mk(0,1,32'h100,1,32'h200,0,0,0,                 0,32'h0,0,0,0,32'h0,32'h0);
    vecs[7]  = mk(0,1,32'h100,1,32'h200,0,1,32'hA000_0000,     1,32'h100,0,1,0,32'hA000_0000,32'h0);
    vecs[8]  = mk(0,1,32'h100,1,32'h200,0,0,0,                 0,32'h100,0,0,0,32'hA000_0000,32'h0);
    vecs[9]  = mk(0,1,32'h100,1,32'h200,0,1,32'hB000_0001,     1,32'h200,1,0,1,32'hA000_0000,32'hB000_0001);
    vecs[10] = mk(0,1,32'h100,1,32'h200,0,0,0,                 0,32'h200,1,0,0,32'hA000_0000,32'hB000_0001);
    vecs[11] = mk(0,1,32'h100,1,32'h200,0,1,32'hA000_0002,     1,32'h100,0,1,0,32'hA000_0002,32'hB000_0001);
    vecs[12] = mk(0,1,32'h100,1,32'h200,0,0,0,                 0,32'h100,0,0,0,32'hA000_0002,32'hB000_0001);
    vecs[13] = mk(0,1,32'h100,1,32'h200,0,1,32'hB000_0003,     1,32'h200,1,0,1,32'hA000_0002,32'hB000_0003);
    vecs[14] = mk(0,1,32'h300,0,0,0,0,0,                       0,32'h200,1,0,0,32'hA000_0002,32'hB000_0003);
    vecs[15] = mk(0,1,32'h300,0,0,1,1,32'hDEAD_BEEF,           1,32'h300,0,0,0,32'hA000_0002,32'hB000_0003);
    vecs[16] = mk(0,1,32'h300,0,0,0,0,0,                       0,32'h300,0,0,0,32'hA000_0002,32'hB000_0003);
    vecs[17] = mk(0,1,32'h300,0,0,0,1,32'hC000_0000,           1,32'h300,0,1,0,32'hC000_0000,32'hB000_0003);
    vecs[18] = mk(0,1,32'h400,1,32'h500,1,0,0,                 0,32'h300,0,0,0,32'hC000_0000,32'hB000_0003);
    vecs[19] = mk(0,1,32'h400,1,32'h500,0,0,0,                 0,32'h300,0,0,0,32'hC000_0000,32'hB000_0003);
    vecs[20] = mk(0,1,32'h400,1,32'h500,0,0,0,                 1,32'h500,1,0,0,32'hC000_0000,32'hB000_0003);
    vecs[21] = mk(0,1,32'h400,0,32'h500,0,1,32'hEEEE_EEEE,     1,32'h500,1,0,0,32'hC000_0000,32'hB000_0003);
    vecs[22] = mk(0,0,0,0,0,0,0,0,                             0,32'h500,1,0,0,32'hC000_0000,32'hB000_0003);

    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      reset_n = !vecs[i].rst;
      way0_request_i = vecs[i].r0; way0_instAddr_i = vecs[i].a0;
      way1_request_i = vecs[i].r1; way1_instAddr_i = vecs[i].a1;
      jumpFlag_i = vecs[i].jmp; icache_dataOk_i = vecs[i].dok; icache_inst_i = vecs[i].inst;
      #3;
      chk($sformatf("v%0d req", i),   32'(icache_request_o), 32'(vecs[i].e_req));
      chk($sformatf("v%0d addr", i),  icache_addr_o,         vecs[i].e_addr);
      chk($sformatf("v%0d grant", i), 32'(grant_o),          32'(vecs[i].e_gnt));
      chk($sformatf("v%0d ok0", i),   32'(way0_dataOk_o),    32'(vecs[i].e_ok0));
      chk($sformatf("v%0d ok1", i),   32'(way1_dataOk_o),    32'(vecs[i].e_ok1));
      chk($sformatf("v%0d inst0", i), way0_inst_o,           vecs[i].e_inst0);
      chk($sformatf("v%0d inst1", i), way1_inst_o,           vecs[i].e_inst1);
      chk($sformatf("v%0d timeout", i), 32'(timeout_o),      32'd0);
    end

    // Jump while waiting: fetch drains, response dropped, other way wins next.
    do_reset();
    drive(0, 0, 1, 32'h600, 0, 0, 0);
    chk("drain idle req", 32'(icache_request_o), 32'd0);
    drive(0, 0, 1, 32'h600, 1, 0, 0);
    chk("drain busy req", 32'(icache_request_o), 32'd1);
    chk("drain busy grant", 32'(grant_o), 32'd1);
    chk("drain busy addr", icache_addr_o, 32'h600);
    drive(0, 0, 1, 32'h600, 1, 0, 0);
    chk("drain hold req", 32'(icache_request_o), 32'd1);
    drive(0, 0, 1, 32'h600, 0, 1, 32'hDEAD_0000);
    chk("drain resp ok0", 32'(way0_dataOk_o), 32'd0);
    chk("drain resp ok1", 32'(way1_dataOk_o), 32'd0);
    chk("drain resp req", 32'(icache_request_o), 32'd1);
    chk("drain inst1 held", way1_inst_o, 32'h0);
    drive(1, 32'h700, 1, 32'h600, 0, 0, 0);
    chk("drain after idle req", 32'(icache_request_o), 32'd0);
    drive(1, 32'h700, 1, 32'h600, 0, 1, 32'h0000_0077);
    chk("drain next grant", 32'(grant_o), 32'd0);
    chk("drain next addr", icache_addr_o, 32'h700);
    chk("drain next ok0", 32'(way0_dataOk_o), 32'd1);
    chk("drain next inst0", way0_inst_o, 32'h0000_0077);
    chk("drain next ok1", 32'(way1_dataOk_o), 32'd0);

    // Withheld response: timeout is sticky and the fetch still completes.
    do_reset();
    drive(1, 32'h900, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      drive(1, 32'h900, 0, 0, 0, 0, 0);
      chk($sformatf("to busy%0d req", k), 32'(icache_request_o), 32'd1);
      if (k <= 3) chk($sformatf("to busy%0d low", k), 32'(timeout_o), 32'd0);
      if (k >= 5) chk($sformatf("to busy%0d high", k), 32'(timeout_o), 32'd1);
    end
    drive(1, 32'h900, 0, 0, 0, 1, 32'h1234_5678);
    chk("to done ok0", 32'(way0_dataOk_o), 32'd1);
    chk("to done inst0", way0_inst_o, 32'h1234_5678);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("to sticky%0d", k), 32'(timeout_o), 32'd1);
      chk($sformatf("to sticky%0d req", k), 32'(icache_request_o), 32'd0);
    end
    do_reset();
    #3;
    chk("to cleared", 32'(timeout_o), 32'd0);

    // Reset in the middle of a fetch: request drops at once, late response ignored.
    drive(1, 32'hA00, 0, 0, 0, 0, 0);
    drive(1, 32'hA00, 0, 0, 0, 0, 0);
    chk("rst busy req", 32'(icache_request_o), 32'd1);
    chk("rst busy addr", icache_addr_o, 32'hA00);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst async req", 32'(icache_request_o), 32'd0);
    chk("rst async addr", icache_addr_o, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    way0_request_i = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 32'hBAD0_BAD0);
    chk("rst late ok0", 32'(way0_dataOk_o), 32'd0);
    chk("rst late ok1", 32'(way1_dataOk_o), 32'd0);
    chk("rst late inst0", way0_inst_o, 32'h0);
    chk("rst late req", 32'(icache_request_o), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("rst after req", 32'(icache_request_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
